// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: runs one data-memory access at a time over a
// req/gnt/rvalid bus, aligns store lanes, extracts and extends load data,
// and stalls the pipeline through hold_req_o while an access is in flight.
module mem_lsu #(
   parameter int unsigned ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic [31:0]       inst_i,
   input  logic [31:0]       instaddr_i,
   input  logic [ADDR_W-1:0] mem_addr_i,
   input  logic [31:0]       st_data_i,
   input  logic              regs_wen_i,
   input  logic [4:0]        rd_addr_i,
   input  logic [31:0]       rd_data_i,
   output logic [31:0]       inst_o,
   output logic [31:0]       instaddr_o,
   output logic              regs_wen_o,
   output logic [4:0]        rd_addr_o,
   output logic [31:0]       rd_data_o,
   output logic              dbus_req_o,
   output logic              dbus_we_o,
   output logic [3:0]        dbus_wem_o,
   output logic [ADDR_W-1:0] dbus_addr_o,
   output logic [31:0]       dbus_wdata_o,
   input  logic              dbus_gnt_i,
   input  logic              dbus_rvalid_i,
   input  logic [31:0]       dbus_rdata_i,
   output logic              hold_req_o,
   output logic              misalign_o
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

   state_t            state;
   logic [ADDR_W-1:0] addr_q;
   logic              we_q;
   logic [3:0]        wem_q;
   logic [31:0]       wdata_q;
   logic [2:0]        f3_q;
   logic [1:0]        off_q;
   logic [31:0]       load_res_q;

   logic [6:0]        opcode;
   logic [2:0]        funct3;
   logic [1:0]        off;
   logic              is_load;
   logic              is_store;
   logic              is_mem;
   logic              mis;
   logic              start;
   logic [3:0]        wem_n;
   logic [31:0]       wdata_n;
   logic [31:0]       shifted;
   logic [31:0]       load_ext;

   // Decode the EX/MEM instruction and detect misaligned accesses
   always_comb begin
      opcode   = inst_i[6:0];
      funct3   = inst_i[14:12];
      off      = mem_addr_i[1:0];
      is_load  = (opcode == 7'b0000011) &&
                 (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
      is_store = (opcode == 7'b0100011) &&
                 (funct3 inside {3'b000, 3'b001, 3'b010});
      is_mem   = is_load || is_store;
      mis      = is_mem && (((funct3[1:0] == 2'b01) && off[0]) ||
                            ((funct3[1:0] == 2'b10) && (off != 2'b00)));
      start    = (state == IDLE) && is_mem && !mis;
   end

   // Build store byte mask and lane-replicated write data
   always_comb begin
      wem_n   = '0;
      wdata_n = st_data_i;
      case (funct3[1:0])
         2'b00: begin
            wem_n   = 4'b0001 << off;
            wdata_n = {4{st_data_i[7:0]}};
         end
         2'b01: begin
            wem_n   = 4'b0011 << off;
            wdata_n = {2{st_data_i[15:0]}};
         end
         default: begin
            wem_n   = 4'hF;
            wdata_n = st_data_i;
         end
      endcase
      if (is_load) wem_n = '0;
   end

   // Select the addressed byte/half from the read word and extend it
   always_comb begin
      shifted = dbus_rdata_i >> {off_q, 3'b000};
      case (f3_q)
         3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
         3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
         3'b100:  load_ext = {24'h0, shifted[7:0]};
         3'b101:  load_ext = {16'h0, shifted[15:0]};
         default: load_ext = dbus_rdata_i;
      endcase
   end

   // Access sequencer: latch request fields, wait for gnt, then rvalid for loads
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state      <= IDLE;
         addr_q     <= '0;
         we_q       <= 1'b0;
         wem_q      <= '0;
         wdata_q    <= '0;
         f3_q       <= '0;
         off_q      <= '0;
         load_res_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  addr_q  <= {mem_addr_i[ADDR_W-1:2], 2'b00};
                  we_q    <= is_store;
                  wem_q   <= wem_n;
                  wdata_q <= wdata_n;
                  f3_q    <= funct3;
                  off_q   <= off;
                  state   <= REQ;
               end
            end
            REQ: begin
               if (dbus_gnt_i) state <= we_q ? DONE : WAIT;
            end
            WAIT: begin
               if (dbus_rvalid_i) begin
                  load_res_q <= load_ext;
                  state      <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Bus drive, stall request and MEM/WB forwarding
   always_comb begin
      dbus_req_o   = (state == REQ);
      dbus_we_o    = we_q;
      dbus_wem_o   = wem_q;
      dbus_addr_o  = addr_q;
      dbus_wdata_o = wdata_q;
      hold_req_o   = rstn && (start || (state == REQ) || (state == WAIT));
      misalign_o   = rstn && mis;
      inst_o       = inst_i;
      instaddr_o   = instaddr_i;
      rd_addr_o    = rd_addr_i;
      rd_data_o    = ((state == DONE) && !we_q) ? load_res_q : rd_data_i;
      regs_wen_o   = 1'b0;
      if (rstn) begin
         if (state == DONE)                regs_wen_o = regs_wen_i;
         else if (state == IDLE && !is_mem) regs_wen_o = regs_wen_i;
      end
   end

endmodule
